fwd_hazard_unit: RTL and testbench

- Parametrised successor to the pipeline forwarding logic: generalised bypass-select for N source operands over M forwarding stages, plus ID-stage hazard detection.
- Adds a registered per-register scoreboard for variable-latency ops (load miss, mul, div) that stalls dependent (RAW) and WAW instructions.
- Sits between the ID and EX stages; drives EX operand muxes and the global pipeline stall.

---
 rtl/fwd_hazard_pkg.sv | 12 +
 rtl/fwd_sb_entry.sv | 19 +
 rtl/fwd_hazard_unit.sv | 86 ++++++++
 tb/tb_fwd_hazard_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/fwd_hazard_pkg.sv
// fwd_hazard_pkg: shared constants, select-width helper and stall-cause type for the forwarding/hazard unit.
package fwd_hazard_pkg;
   localparam int DEF_REG_AW   = 5;
   localparam int DEF_NUM_REGS = 2**DEF_REG_AW;
   localparam int FSEL_RF      = 0;

   typedef enum logic [1:0] {CAUSE_NONE, CAUSE_LD_USE, CAUSE_RAW, CAUSE_WAW} stall_cause_e;

   function automatic int fwd_sel_w(input int num_fwd);
      return $clog2(num_fwd + 1);
   endfunction
endpackage

// File: rtl/fwd_sb_entry.sv
// fwd_sb_entry: one scoreboard slot, a load/decrement latency counter that reports busy while non-zero.
module fwd_sb_entry #(
   parameter int LAT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [LAT_W-1:0] lat,
   output logic             busy
);
   logic [LAT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= lat;
      else if (busy) cnt <= cnt - 1'b1;

   assign busy = cnt != '0;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX bypass select, ID load-use/RAW/WAW stall and a per-register latency scoreboard.
// Optional stall-cause perf counters when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_unit import fwd_hazard_pkg::*; #(
   parameter  int NUM_SRC  = 2,
   parameter  int NUM_FWD  = 2,
   parameter  int REG_AW   = DEF_REG_AW,
   parameter  int LAT_W    = 6,
   localparam int SEL_W    = fwd_sel_w(NUM_FWD),
   localparam int NUM_REGS = 2**REG_AW
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs,
   input  logic [NUM_SRC-1:0]        id_rs_used,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic                      id_regwrite,
   input  logic [REG_AW-1:0]         ex_rd,
   input  logic                      ex_regwrite,
   input  logic                      ex_is_load,
   input  logic [NUM_FWD*REG_AW-1:0] stg_rd,
   input  logic [NUM_FWD-1:0]        stg_regwrite,
   input  logic                      lc_issue,
   input  logic [REG_AW-1:0]         lc_rd,
   input  logic [LAT_W-1:0]          lc_lat,
   output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
   output logic                      stall,
`ifdef FWD_HAZARD_PERF_EN
   output logic [31:0]               perf_stall_raw,
   output logic [31:0]               perf_stall_waw,
   output logic [31:0]               perf_stall_ld,
`endif
   output logic [NUM_REGS-1:0]       busy_vec
);
   logic ld_use, raw, waw;
   stall_cause_e cause;

   // Scan oldest to youngest so the youngest matching stage is written last and wins.
   always_comb begin
      fwd_sel = {NUM_SRC{SEL_W'(FSEL_RF)}};
      for (int s = 0; s < NUM_SRC; s++)
         for (int k = NUM_FWD - 1; k >= 0; k--)
            if (stg_regwrite[k] && stg_rd[k*REG_AW +: REG_AW] != '0 &&
                stg_rd[k*REG_AW +: REG_AW] == ex_rs[s*REG_AW +: REG_AW])
               fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
   end

   always_comb begin
      ld_use = 1'b0;
      raw    = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         ld_use = ld_use | (ex_is_load && ex_regwrite && ex_rd != '0 &&
                            ex_rd == id_rs[s*REG_AW +: REG_AW] && id_rs_used[s]);
         raw    = raw | (busy_vec[id_rs[s*REG_AW +: REG_AW]] && id_rs_used[s] &&
                         id_rs[s*REG_AW +: REG_AW] != '0);
      end
      waw   = id_regwrite && id_rd != '0 && busy_vec[id_rd];
      cause = ld_use ? CAUSE_LD_USE : raw ? CAUSE_RAW : waw ? CAUSE_WAW : CAUSE_NONE;
      stall = cause != CAUSE_NONE;
   end

   // x0 never becomes busy, so it gets no counter.
   assign busy_vec[0] = 1'b0;
   for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
      fwd_sb_entry #(.LAT_W(LAT_W)) u_sb (
         .clk  (clk),
         .rst_n(rst_n),
         .load (lc_issue && lc_rd == REG_AW'(r) && lc_lat != '0),
         .lat  (lc_lat),
         .busy (busy_vec[r])
      );
   end

`ifdef FWD_HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         perf_stall_raw <= '0;
         perf_stall_waw <= '0;
         perf_stall_ld  <= '0;
      end else begin
         if (cause == CAUSE_LD_USE && perf_stall_ld  != '1) perf_stall_ld  <= perf_stall_ld  + 1'b1;
         if (cause == CAUSE_RAW    && perf_stall_raw != '1) perf_stall_raw <= perf_stall_raw + 1'b1;
         if (cause == CAUSE_WAW    && perf_stall_waw != '1) perf_stall_waw <= perf_stall_waw + 1'b1;
      end
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors for bypass select, stall causes and scoreboard timing.
module tb_fwd_hazard_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  ex_rs, id_rs, stg_rd;
   logic [1:0]  id_rs_used, stg_regwrite;
   logic [4:0]  id_rd, ex_rd, lc_rd;
   logic        id_regwrite, ex_regwrite, ex_is_load, lc_issue;
   logic [5:0]  lc_lat;
   logic [3:0]  fwd_sel;
   logic        stall;
   logic [31:0] busy_vec;
`ifdef FWD_HAZARD_PERF_EN
   logic [31:0] perf_stall_raw, perf_stall_waw, perf_stall_ld;
`endif
   int total = 0, passed = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit dut (
      .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .id_rs(id_rs), .id_rs_used(id_rs_used),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_is_load(ex_is_load), .stg_rd(stg_rd), .stg_regwrite(stg_regwrite),
      .lc_issue(lc_issue), .lc_rd(lc_rd), .lc_lat(lc_lat), .fwd_sel(fwd_sel), .stall(stall),
`ifdef FWD_HAZARD_PERF_EN
      .perf_stall_raw(perf_stall_raw), .perf_stall_waw(perf_stall_waw), .perf_stall_ld(perf_stall_ld),
`endif
      .busy_vec(busy_vec)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      {ex_rs, id_rs, stg_rd, id_rs_used, stg_regwrite} = '0;
      {id_rd, ex_rd, lc_rd, id_regwrite, ex_regwrite, ex_is_load, lc_issue, lc_lat} = '0;
      #12;
      check("rst_busy", busy_vec, 0);
      check("rst_fwd", fwd_sel, 0);
      check("rst_stall", stall, 0);
      rst_n = 1'b1;
      tick();

      stg_rd = {5'd5, 5'd5}; stg_regwrite = 2'b11; ex_rs = {5'd5, 5'd7}; #1;
      check("fwd_youngest", fwd_sel, 4'b0100);
      stg_regwrite = 2'b10; #1;
      check("fwd_oldest", fwd_sel, 4'b1000);
      ex_rs = {5'd7, 5'd5}; #1;
      check("fwd_src0_oldest", fwd_sel, 4'b0010);
      stg_regwrite = 2'b00; #1;
      check("fwd_no_we", fwd_sel, 4'b0000);
      stg_rd = '0; stg_regwrite = 2'b11; ex_rs = '0; #1;
      check("fwd_x0", fwd_sel, 4'b0000);
      stg_regwrite = 2'b00;

      ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd3;
      id_rs = {5'd4, 5'd3}; id_rs_used = 2'b01; #1;
      check("ld_use_used", stall, 1);
      id_rs_used = 2'b10; #1;
      check("ld_use_unused", stall, 0);
      ex_rd = 5'd0; id_rs = '0; id_rs_used = 2'b11; #1;
      check("ld_use_x0", stall, 0);
      ex_is_load = 1'b0; ex_regwrite = 1'b0;

      id_rs = {5'd1, 5'd9}; id_rs_used = 2'b01;
      lc_issue = 1'b1; lc_rd = 5'd9; lc_lat = 6'd4;
      tick();
      lc_issue = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("sb_busy_%0d", i), busy_vec[9], 1);
         check($sformatf("sb_raw_%0d", i), stall, 1);
         tick();
      end
      check("sb_release_busy", busy_vec, 0);
      check("sb_release_stall", stall, 0);

      id_rs_used = 2'b00;
      lc_issue = 1'b1; lc_lat = 6'd4;
      tick();
      lc_issue = 1'b0;
      id_rd = 5'd9; id_regwrite = 1'b1; #1;
      check("waw_stall", stall, 1);
      id_regwrite = 1'b0; #1;
      check("waw_no_we", stall, 0);
      tick(); tick(); tick();
      check("waw_cnt1_busy", busy_vec[9], 1);
      lc_issue = 1'b1; lc_lat = 6'd6;
      tick();
      lc_issue = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("reissue_busy_%0d", i), busy_vec[9], 1);
      end
      tick();
      check("reissue_done", busy_vec, 0);

      lc_issue = 1'b1; lc_rd = 5'd0; lc_lat = 6'd8;
      tick();
      check("ign_rd0", busy_vec, 0);
      lc_rd = 5'd4; lc_lat = 6'd0;
      tick();
      check("ign_lat0", busy_vec, 0);

      lc_rd = 5'd12; lc_lat = 6'd5;
      tick();
      lc_issue = 1'b0;
      tick(); tick();
      check("pre_rst_busy", busy_vec, 32'h0000_1000);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", busy_vec, 0);
`ifdef FWD_HAZARD_PERF_EN
      check("async_rst_perf_raw", perf_stall_raw, 0);
      check("async_rst_perf_waw", perf_stall_waw, 0);
      check("async_rst_perf_ld", perf_stall_ld, 0);
`endif
      rst_n = 1'b1;
      tick();
      check("post_rst_busy", busy_vec, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
